spi_slave_receiver: RTL and testbench
=====================================

SPI_SLAVE_RECEIVER -- requirements
Module: spi_slave_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for io_SCK, io_CS and io_DI (minimum 2).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state SHALL be on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port io_SCK, input, 1, SPI serial clock, sampled by clock.
REQ-005 SHALL have port io_CS, input, 1, active-low chip select.
REQ-006 SHALL have port io_DI, input, 1, SPI data in (MOSI), MSB first.
REQ-007 SHALL have port io_DataBlockSize, input, 8, data-block length in bytes for CMD24; 0 means 256.
REQ-008 SHALL have port io_CommandReadFinished, output, 1, set once the 6 command bits are captured.
REQ-009 SHALL have port io_ArgumentReadFinished, output, 1, set once the 32 argument bits are captured.
REQ-010 SHALL have port io_ReadSuccess, output, 1, set when a frame completes validly.
REQ-011 SHALL have port io_Command, output, 6, last captured command index.
REQ-012 SHALL have port io_CommandArgument, output, 32, last captured argument, MSB first.
REQ-013 SHALL have port io____state, output, 3, current FSM state code (debug).

Function
REQ-014 SHALL sample each SPI input through SYNC_STAGES flops; rising edge of synchronized SCK while synchronized CS=0 SHALL shift synchronized DI into an 8-bit buffer (shift left, new bit at bit 0) and pulse an internal "changed" strobe for exactly one clock.
REQ-015 SHALL process exactly one bit (buffer bit 0) per changed strobe; no state change without a strobe.
REQ-016 FSM codes: IDLE=0, TRANS=1, CMD=2, ARG=3, CRC=4, END=5, TOKEN=6, DATA=7.
REQ-017 IDLE: bit 1 ignored; bit 0 (start) -> TRANS and clear io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess.
REQ-018 TRANS: record transmission bit -> CMD.
REQ-019 CMD: shift 6 bits into io_Command; on 6th bit set io_CommandReadFinished -> ARG.
REQ-020 ARG: shift 32 bits into io_CommandArgument; on 32nd bit set io_ArgumentReadFinished -> CRC.
REQ-021 CRC: consume 7 bits into an internal crc register -> END.
REQ-022 END: io_ReadSuccess=1 iff end bit=1 and transmission bit=1 (plus REQ-028); then -> TOKEN if success and io_Command=24, else IDLE.
REQ-023 TOKEN: on a strobe where the 8-bit buffer equals 8'hFE -> DATA with bit counter cleared.
REQ-024 DATA: consume (N*8+16) bits, N = io_DataBlockSize (0 -> 256), then -> IDLE; io_DataBlockSize sampled on TOKEN->DATA transition.
REQ-025 Synchronized CS=1 SHALL force IDLE on the next clock from any state, clear bit counters, and leave io_Command/io_CommandArgument/flags unchanged.
REQ-026 Flags and captured fields SHALL hold until the next start bit or reset.

Reset
REQ-027 reset SHALL asynchronously force: state IDLE, buffer 8'h00, strobe 0, all counters 0, io_Command 0, io_CommandArgument 0, all three flags 0; synchronizer flops reset to SCK=0, CS=1, DI=1.

Configuration
REQ-028 Macro SPI_RX_CRC7_CHECK_EN: when defined, io_ReadSuccess additionally requires received CRC7 (poly x^7+x^3+1, init 0) over the first 40 frame bits to match; when undefined, CRC bits are consumed and ignored.

Structure
REQ-029 Shared package spi_rx_pkg SHALL hold the state enum, field widths (6, 32, 7), CMD24 constant and token 8'hFE.
REQ-030 Sub-module spi_buffer SHALL implement REQ-014 (synchronizers, edge detect, 8-bit shift buffer, changed strobe).

Verification
REQ-031 Reset, CS=0, eight SCK pulses with DI=1 -> io____state stays 0, all flags 0.
REQ-032 Send 0,1, cmd 6'd59, arg 32'd128913, seven 1s, end 1 (macro off) -> io_Command=59, io_CommandArgument=0x0001F791, all three flags 1, state 0.
REQ-033 Same frame with end bit 0 -> io_ReadSuccess=0, io_ArgumentReadFinished=1, state 0.
REQ-034 Raise CS after 20 argument bits -> state 0 next clock, io_ArgumentReadFinished stays 0; next full frame succeeds.
REQ-035 Valid CMD24 frame, io_DataBlockSize=2, byte 8'hFE, then 32 bits -> states 6, 7, then 0.
REQ-036 Macro defined, frame with wrong CRC7 -> io_ReadSuccess=0; correct CRC7 -> 1.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI slave command receiver.
// CRC7 helper is used only when SPI_RX_CRC7_CHECK_EN is defined.
package spi_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRANS = 3'd1,
        ST_CMD   = 3'd2,
        ST_ARG   = 3'd3,
        ST_CRC   = 3'd4,
        ST_END   = 3'd5,
        ST_TOKEN = 3'd6,
        ST_DATA  = 3'd7
    } state_t;

    localparam int unsigned CMD_W = 6;
    localparam int unsigned ARG_W = 32;
    localparam int unsigned CRC_W = 7;

    localparam logic [CMD_W-1:0] CMD24      = 6'd24;
    localparam logic [7:0]       DATA_TOKEN = 8'hFE;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/spi_buffer.sv
// Synchronizes SCK/CS/DI into the clock domain and shifts DI into an
// 8-bit buffer on each synchronized SCK rising edge while CS is low.
module spi_buffer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs,
    input  logic       di,
    output logic [7:0] buffer,
    output logic       changed,
    output logic       cs_sync
);

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] di_sr;
    logic                   sck_prev;
    logic                   sck_s;
    logic                   di_s;

    assign sck_s   = sck_sr[SYNC_STAGES-1];
    assign di_s    = di_sr[SYNC_STAGES-1];
    assign cs_sync = cs_sr[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sr   <= '0;
            cs_sr    <= '1;
            di_sr    <= '1;
            sck_prev <= 1'b0;
            buffer   <= '0;
            changed  <= 1'b0;
        end else begin
            sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
            cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs};
            di_sr    <= {di_sr[SYNC_STAGES-2:0], di};
            sck_prev <= sck_s;
            changed  <= 1'b0;
            if (sck_s && !sck_prev && !cs_sync) begin
                buffer  <= {buffer[6:0], di_s};
                changed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI slave command-frame receiver (start, transmission, cmd, arg, crc, end),
// with CMD24 data-token/block skipping. Define SPI_RX_CRC7_CHECK_EN to check CRC7.
module spi_slave_receiver
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_SCK,
    input  logic              io_CS,
    input  logic              io_DI,
    input  logic [7:0]        io_DataBlockSize,
    output logic              io_CommandReadFinished,
    output logic              io_ArgumentReadFinished,
    output logic              io_ReadSuccess,
    output logic [CMD_W-1:0]  io_Command,
    output logic [ARG_W-1:0]  io_CommandArgument,
    output logic [2:0]        io____state
);

    logic [7:0]  buffer;
    logic        changed;
    logic        cs_s;
    logic        rx_bit;
    logic        trans_bit;
    logic        frame_ok;
    logic [11:0] cnt;
    logic [11:0] data_last;
    logic [8:0]  block_bytes;
    state_t      state;
`ifdef SPI_RX_CRC7_CHECK_EN
    logic [CRC_W-1:0] crc_rx;
    logic [CRC_W-1:0] crc_calc;
`endif

    spi_buffer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_buffer (
        .clock   (clock),
        .reset   (reset),
        .sck     (io_SCK),
        .cs      (io_CS),
        .di      (io_DI),
        .buffer  (buffer),
        .changed (changed),
        .cs_sync (cs_s)
    );

    assign rx_bit      = buffer[0];
    assign io____state = state;
    assign block_bytes = (io_DataBlockSize == 8'd0) ? 9'd256 : {1'b0, io_DataBlockSize};

    always_comb begin
        frame_ok = rx_bit & trans_bit;
`ifdef SPI_RX_CRC7_CHECK_EN
        frame_ok = frame_ok & (crc_rx == crc_calc);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                   <= ST_IDLE;
            cnt                     <= '0;
            data_last               <= '0;
            trans_bit               <= 1'b0;
            io_Command              <= '0;
            io_CommandArgument      <= '0;
            io_CommandReadFinished  <= 1'b0;
            io_ArgumentReadFinished <= 1'b0;
            io_ReadSuccess          <= 1'b0;
`ifdef SPI_RX_CRC7_CHECK_EN
            crc_rx                  <= '0;
            crc_calc                <= '0;
`endif
        end else if (cs_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (changed) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state                   <= ST_TRANS;
                        cnt                     <= '0;
                        io_CommandReadFinished  <= 1'b0;
                        io_ArgumentReadFinished <= 1'b0;
                        io_ReadSuccess          <= 1'b0;
`ifdef SPI_RX_CRC7_CHECK_EN
                        crc_calc                <= crc7_step('0, rx_bit);
`endif
                    end
                end
                ST_TRANS: begin
                    trans_bit <= rx_bit;
                    state     <= ST_CMD;
`ifdef SPI_RX_CRC7_CHECK_EN
                    crc_calc  <= crc7_step(crc_calc, rx_bit);
`endif
                end
                ST_CMD: begin
                    io_Command <= {io_Command[CMD_W-2:0], rx_bit};
`ifdef SPI_RX_CRC7_CHECK_EN
                    crc_calc   <= crc7_step(crc_calc, rx_bit);
`endif
                    if (cnt == 12'(CMD_W - 1)) begin
                        cnt                    <= '0;
                        io_CommandReadFinished <= 1'b1;
                        state                  <= ST_ARG;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                ST_ARG: begin
                    io_CommandArgument <= {io_CommandArgument[ARG_W-2:0], rx_bit};
`ifdef SPI_RX_CRC7_CHECK_EN
                    crc_calc           <= crc7_step(crc_calc, rx_bit);
`endif
                    if (cnt == 12'(ARG_W - 1)) begin
                        cnt                     <= '0;
                        io_ArgumentReadFinished <= 1'b1;
                        state                   <= ST_CRC;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                ST_CRC: begin
`ifdef SPI_RX_CRC7_CHECK_EN
                    crc_rx <= {crc_rx[CRC_W-2:0], rx_bit};
`endif
                    if (cnt == 12'(CRC_W - 1)) begin
                        cnt   <= '0;
                        state <= ST_END;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                ST_END: begin
                    io_ReadSuccess <= frame_ok;
                    state <= (frame_ok && io_Command == CMD24) ? ST_TOKEN : ST_IDLE;
                end
                ST_TOKEN: begin
                    if (buffer == DATA_TOKEN) begin
                        state     <= ST_DATA;
                        cnt       <= '0;
                        // block bytes * 8 + 16 CRC bits, stored as last index
                        data_last <= {block_bytes, 3'b000} + 12'd15;
                    end
                end
                ST_DATA: begin
                    if (cnt == data_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Scoreboard bench for spi_slave_receiver: expected state transitions are queued
// by the stimulus and checked by a monitor on every observed state change.
module tb_spi_slave_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_SCK;
    logic        io_CS;
    logic        io_DI;
    logic [7:0]  io_DataBlockSize;
    logic        io_CommandReadFinished;
    logic        io_ArgumentReadFinished;
    logic        io_ReadSuccess;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic [2:0]  io____state;

    typedef struct {
        logic [2:0]  st;
        int unsigned lvl;   // 0: state only, 1: +flags/cmd, 2: +argument
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [2:0]  flags; // {cmd finished, arg finished, success}
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    spi_slave_receiver #(
        .SYNC_STAGES(2)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_SCK                  (io_SCK),
        .io_CS                   (io_CS),
        .io_DI                   (io_DI),
        .io_DataBlockSize        (io_DataBlockSize),
        .io_CommandReadFinished  (io_CommandReadFinished),
        .io_ArgumentReadFinished (io_ArgumentReadFinished),
        .io_ReadSuccess          (io_ReadSuccess),
        .io_Command              (io_Command),
        .io_CommandArgument      (io_CommandArgument),
        .io____state             (io____state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [2:0] st, input int unsigned lvl,
                                 input logic [5:0] cmd, input logic [31:0] arg,
                                 input logic [2:0] flags);
        exp_t e;
        e.st = st; e.lvl = lvl; e.cmd = cmd; e.arg = arg; e.flags = flags;
        q.push_back(e);
    endfunction

    function automatic void push_hdr();
        for (int s = 1; s <= 5; s++) push(3'(s), 0, '0, '0, '0);
    endfunction

    function automatic logic [6:0] frame_crc(input logic [5:0] cmd, input logic [31:0] arg);
        logic [39:0] bits;
        logic [6:0]  c;
        logic        fb;
        bits = {2'b01, cmd, arg};
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ bits[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
`ifdef SPI_RX_CRC7_CHECK_EN
        return c;
`else
        return (c == c) ? 7'h7F : 7'h00;
`endif
    endfunction

    // Monitor: every change of the state output pops one expectation
    initial begin : monitor
        logic [2:0] prev_st;
        exp_t e;
        prev_st = 3'd0;
        forever begin
            @(negedge clock);
            if (!reset && io____state !== prev_st) begin
                if (q.size() == 0) begin
                    check("unexpected_transition", {29'd0, io____state}, {29'd0, prev_st});
                end else begin
                    e = q.pop_front();
                    check("state", {29'd0, io____state}, {29'd0, e.st});
                    if (e.lvl >= 1) begin
                        check("flags", {29'd0, io_CommandReadFinished, io_ArgumentReadFinished,
                                        io_ReadSuccess}, {29'd0, e.flags});
                        check("command", {26'd0, io_Command}, {26'd0, e.cmd});
                    end
                    if (e.lvl >= 2) check("argument", io_CommandArgument, e.arg);
                end
            end
            prev_st = io____state;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        io_DI = b;
        tick(3);
        io_SCK = 1'b1;
        tick(4);
        io_SCK = 1'b0;
        tick(3);
    endtask

    task automatic send_bits(input logic [39:0] v, input int unsigned n);
        for (int i = int'(n) - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg,
                              input logic [6:0] crc, input logic endb);
        send_bits(40'({2'b01, cmd}), 8);
        send_bits(40'(arg), 32);
        send_bits(40'(crc), 7);
        spi_bit(endb);
    endtask

    initial begin : stimulus
        logic [6:0] crc_a;
        logic [6:0] crc_24;
        reset = 1'b1;
        io_SCK = 1'b0;
        io_CS = 1'b1;
        io_DI = 1'b1;
        io_DataBlockSize = 8'd2;
        tick(5);
        reset = 1'b0;
        tick(2);
        check("reset_state", {29'd0, io____state}, 32'd0);
        check("reset_flags", {29'd0, io_CommandReadFinished, io_ArgumentReadFinished,
                              io_ReadSuccess}, 32'd0);
        check("reset_command", {26'd0, io_Command}, 32'd0);
        check("reset_argument", io_CommandArgument, 32'd0);

        // Idle ones are ignored
        io_CS = 1'b0;
        tick(4);
        send_bits(40'hFF, 8);
        check("idle_ones_state", {29'd0, io____state}, 32'd0);
        check("idle_ones_flags", {29'd0, io_CommandReadFinished, io_ArgumentReadFinished,
                                  io_ReadSuccess}, 32'd0);

        // Valid CMD59 frame
        crc_a = frame_crc(6'd59, 32'd128913);
        push_hdr();
        push(3'd0, 2, 6'd59, 32'h0001F791, 3'b111);
        send_frame(6'd59, 32'd128913, crc_a, 1'b1);

        // Same frame, bad end bit
        push_hdr();
        push(3'd0, 2, 6'd59, 32'h0001F791, 3'b110);
        send_frame(6'd59, 32'd128913, crc_a, 1'b0);

        // CS abort after 20 argument bits, then a full good frame
        push(3'd1, 0, '0, '0, '0);
        push(3'd2, 0, '0, '0, '0);
        push(3'd3, 0, '0, '0, '0);
        push(3'd0, 1, 6'd17, '0, 3'b100);
        send_bits(40'({2'b01, 6'd17}), 8);
        send_bits(40'h00000ABCDE, 20);
        io_CS = 1'b1;
        tick(6);
        check("abort_arg_flag", {31'd0, io_ArgumentReadFinished}, 32'd0);
        io_CS = 1'b0;
        tick(4);
        push_hdr();
        push(3'd0, 2, 6'd59, 32'h0001F791, 3'b111);
        send_frame(6'd59, 32'd128913, crc_a, 1'b1);

        // CMD24 with token and 2-byte block (+16 CRC bits)
        crc_24 = frame_crc(6'd24, 32'h00000200);
        io_DataBlockSize = 8'd2;
        push_hdr();
        push(3'd6, 0, '0, '0, '0);
        push(3'd7, 0, '0, '0, '0);
        push(3'd0, 2, 6'd24, 32'h00000200, 3'b111);
        send_frame(6'd24, 32'h00000200, crc_24, 1'b1);
        send_bits(40'hFE, 8);
        send_bits(40'h00A53CFF, 31);
        check("data_not_done", {29'd0, io____state}, 32'd7);
        spi_bit(1'b1);

`ifdef SPI_RX_CRC7_CHECK_EN
        push_hdr();
        push(3'd0, 2, 6'd59, 32'h0001F791, 3'b110);
        send_frame(6'd59, 32'd128913, crc_a ^ 7'h01, 1'b1);
        push_hdr();
        push(3'd0, 2, 6'd59, 32'h0001F791, 3'b111);
        send_frame(6'd59, 32'd128913, crc_a, 1'b1);
`else
        // CRC content is ignored in this build
        push_hdr();
        push(3'd0, 2, 6'd59, 32'h0001F791, 3'b111);
        send_frame(6'd59, 32'd128913, 7'h00, 1'b1);
`endif

        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        check("scoreboard_drained", q.size(), 32'd0);
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
